bbox_scan_ctrl: RTL and testbench

//  Sequencer for the bounding-box datapath. On a start pulse it clears the datapath accumulators.
//  It then walks the image RAM in raster order (x fastest, then y) and streams each pixel with
//  its (x,y) coordinates over a valid/ready interface. It raises done after the last pixel is accepted.
//  It sits between the image RAM (synchronous read port) and the bounding-box compare logic in boundingBoxTop.

---
 rtl/bbox_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bbox_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bbox_scan_ctrl.sv
// bbox_scan_ctrl: frame sequencer for the bounding-box datapath.
// Clears the accumulators, then reads the image RAM in raster order. Each pixel
// is streamed with its (x,y) over valid/ready. A 2-entry skid FIFO absorbs stalls.
// When the buffer is empty, the returning RAM word is bypassed straight to the
// output, so the first pixel appears one cycle after the first read.
module bbox_scan_ctrl #(
    parameter int IMG_W  = 768,
    parameter int IMG_H  = 512,
    parameter int PIX_W  = 24,
    parameter int ADDR_W = 19,
    parameter int X_W    = 10,
    parameter int Y_W    = 10
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [PIX_W-1:0]  ram_q,
    output logic              bb_clear,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic             last;
    } pix_t;

    state_t         state, state_nxt;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           issue_last;

    // tag of the read whose data returns this cycle
    logic           inflight;
    logic [X_W-1:0] inf_x;
    logic [Y_W-1:0] inf_y;
    logic           inf_last;

    pix_t           fifo [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     occ;

    pix_t           arrive, head;
    logic           hs, push, pop;
    logic [2:0]     used;

    assign issue_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    assign arrive    = '{data: ram_q, x: inf_x, y: inf_y, last: inf_last};
    assign head      = (occ != 2'd0) ? fifo[rd_ptr] : arrive;
    assign pix_valid = (occ != 2'd0) | inflight;
    assign hs        = pix_valid & pix_ready;
    // the returning word is buffered unless it bypasses and is taken right away
    assign push      = inflight & ~((occ == 2'd0) & hs);
    assign pop       = hs & (occ != 2'd0);

    // entries still owed to the consumer after this cycle's handshake; keep <= 2
    assign used   = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
    assign ram_rd = (state == S_SCAN) & ~abort & (used < 3'd2);

    assign pix_data = pix_valid ? head.data : '0;
    assign pix_x    = pix_valid ? head.x    : '0;
    assign pix_y    = pix_valid ? head.y    : '0;
    assign pix_last = pix_valid & head.last;

    // next-state decision; abort overrides everything including start
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state_nxt = S_CLEAR;
                S_CLEAR: state_nxt = S_SCAN;
                S_SCAN:  if (ram_rd && issue_last) state_nxt = S_DRAIN;
                S_DRAIN: if (hs && head.last) state_nxt = S_DONE;
                S_DONE:  if (start) state_nxt = S_CLEAR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // state register with registered status flags
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bb_clear <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bb_clear <= (state_nxt == S_CLEAR);
            busy     <= (state_nxt == S_CLEAR) || (state_nxt == S_SCAN) || (state_nxt == S_DRAIN);
            done     <= (state_nxt == S_DONE);
        end
    end

    // linear address and raster x/y advance once per issued read
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (state == S_CLEAR) begin
            ram_addr <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (ram_rd) begin
            ram_addr <= ram_addr + 1'b1;
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // coordinates ride along with the read for one cycle
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            inf_x    <= '0;
            inf_y    <= '0;
            inf_last <= 1'b0;
        end else begin
            inflight <= ram_rd;
            if (ram_rd) begin
                inf_x    <= x_cnt;
                inf_y    <= y_cnt;
                inf_last <= issue_last;
            end
        end
    end

    // skid FIFO pointers and occupancy; abort discards buffered pixels
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      occ <= occ + 2'd1;
            else if (pop && !push) occ <= occ - 2'd1;
        end
    end

    // FIFO storage; contents only matter while occupied
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else if (push && !abort) begin
            fifo[wr_ptr] <= arrive;
        end
    end

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Randomized bench for bbox_scan_ctrl: 4x3 frame under several ready patterns,
// abort, start filtering, async reset mid-drain, plus a 1x1 instance.
module tb_bbox_scan_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, pix_ready;
    logic        ram_rd, bb_clear, pix_valid, pix_last, busy, done;
    logic [18:0] ram_addr;
    logic [23:0] ram_q;
    logic [23:0] pix_data;
    logic [9:0]  pix_x, pix_y;

    logic        s_start, s_rd, s_clr, s_valid, s_last, s_busy, s_done;
    logic [18:0] s_addr;
    logic [23:0] s_q, s_data, s_word;
    logic [9:0]  s_x, s_y;

    logic [23:0] mem [0:N-1];
    int          n_vec = 0, n_err = 0;
    int          exp_idx, issued, acc, clr_cnt, ready_mode;
    bit          mon_en = 0, prev_stall = 0;
    logic [63:0] cur, prev;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q), .bb_clear(bb_clear),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .busy(busy), .done(done)
    );

    bbox_scan_ctrl #(.IMG_W(1), .IMG_H(1)) u_dut1 (
        .CLOCK_50(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
        .ram_rd(s_rd), .ram_addr(s_addr), .ram_q(s_q), .bb_clear(s_clr),
        .pix_valid(s_valid), .pix_ready(1'b1), .pix_data(s_data),
        .pix_x(s_x), .pix_y(s_y), .pix_last(s_last), .busy(s_busy), .done(s_done)
    );

    // synchronous-read RAM models
    always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr[3:0]];
    always @(posedge clk) if (s_rd) s_q <= s_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input logic [9:0] x, input logic [9:0] y,
                                       input logic [23:0] d, input logic l);
        return {19'd0, x, y, d, l};
    endfunction

    // ready pattern generator
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
        endcase
    end

    // scoreboard: pixel k must be (k%W, k/W, mem[k]); last only for k==N-1
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            cur = pk(pix_x, pix_y, pix_data, pix_last);
            if (bb_clear) clr_cnt++;
            if (prev_stall) chk("stable", cur, prev);
            if (pix_valid && pix_ready) begin
                if (exp_idx < N)
                    chk("pix", cur, pk(10'(exp_idx % W), 10'(exp_idx / W), mem[exp_idx], exp_idx == N-1));
                else
                    chk("extra_pix", 64'(exp_idx), 64'(N-1));
                exp_idx++;
                acc++;
            end
            if (ram_rd) begin
                issued++;
                chk("ahead_le2", 64'(issued - acc <= 2), 64'd1);
            end
            prev_stall = pix_valid && !pix_ready;
            prev       = cur;
        end
    end

    task automatic start_frame();
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        exp_idx = 0; issued = 0; acc = 0; clr_cnt = 0; prev_stall = 0; mon_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("bb_clear_t1", bb_clear, 1); chk("done_t1", done, 0); chk("busy_t1", busy, 1);
        @(negedge clk);
        chk("ram_rd_t2", ram_rd, 1); chk("valid_t2", pix_valid, 0); chk("clear_t2", bb_clear, 0);
        @(negedge clk);
        chk("valid_t3", pix_valid, 1);
    endtask

    task automatic finish_frame(input int mode, input bit stall, input bit inject);
        int cyc = 0;
        bit ok = 0;
        while (cyc < 400 && !ok) begin
            @(negedge clk); cyc++;
            if (stall && cyc == 20) begin
                chk("stall_reads", 64'(issued), 64'd2);
                chk("stall_rd", ram_rd, 0);
                ready_mode = mode;
            end
            if (inject && cyc == 4) start = 1'b1;
            if (inject && cyc == 5) start = 1'b0;
            if (done) ok = 1;
        end
        chk("done_seen", ok, 1);
        if (mode == 0 && !stall && !inject) chk("done_lat", 64'(cyc), 64'd12);
        chk("busy_at_done", busy, 0);
        chk("pix_count", 64'(exp_idx), 64'(N));
        chk("clr_once", 64'(clr_cnt), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("reads_total", 64'(issued), 64'(N));
    endtask

    task automatic run_frame(input int mode, input bit stall, input bit inject);
        ready_mode = stall ? 3 : mode;
        pix_ready  = (stall || mode == 1) ? 1'b0 : 1'b1;
        start_frame();
        finish_frame(mode, stall, inject);
    endtask

    initial begin
        int cyc;
        int n_pix, n_rd;
        bit ok;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0; s_word = '0;
        ready_mode = 0; pix_ready = 1'b1;
        #12;
        chk("rst_valid", pix_valid, 0); chk("rst_rd", ram_rd, 0); chk("rst_done", done, 0);
        chk("rst_busy", busy, 0); chk("rst_addr", 64'(ram_addr), 0); chk("rst_clr", bb_clear, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0); chk("idle_rd", ram_rd, 0);

        run_frame(0, 0, 0);   // full throughput, exact latencies
        run_frame(1, 0, 0);   // toggling ready; start issued from DONE
        run_frame(0, 1, 0);   // ready low 20 cycles first
        run_frame(2, 0, 1);   // random ready, extra start mid-scan

        // abort mid-scan at the 5th pixel, then rescan
        ready_mode = 1; pix_ready = 1'b0;
        start_frame();
        cyc = 0;
        while (cyc < 200 && exp_idx < 4) begin @(negedge clk); cyc++; end
        chk("abort_reach", 64'(exp_idx >= 4), 64'd1);
        chk("abort_in_scan", busy, 1);
        mon_en = 0; prev_stall = 0;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", pix_valid, 0); chk("abort_done", done, 0); chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_rd", ram_rd, 0); chk("abort_valid2", pix_valid, 0);
        run_frame(2, 0, 0);

        // 1x1 image
        s_word = 24'($urandom);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n_pix = 0; n_rd = 0; ok = 0; cyc = 0;
        while (cyc < 50 && !ok) begin
            @(negedge clk); cyc++;
            if (s_rd) begin n_rd++; chk("one_addr", 64'(s_addr), 0); end
            if (s_valid) begin n_pix++; chk("one_pix", pk(s_x, s_y, s_data, s_last), pk(0, 0, s_word, 1)); end
            if (s_done) ok = 1;
        end
        chk("one_done", ok, 1); chk("one_npix", 64'(n_pix), 1); chk("one_nrd", 64'(n_rd), 1);

        // async reset while a pixel is pending in DRAIN
        ready_mode = 1; pix_ready = 1'b0;
        start_frame();
        cyc = 0; ok = 0;
        while (cyc < 200 && !ok) begin
            @(negedge clk); cyc++;
            if (ram_rd && ram_addr == 19'(N-1)) begin ok = 1; ready_mode = 3; end
        end
        chk("drain_reach", ok, 1);
        @(posedge clk); #3;
        chk("drain_busy", busy, 1); chk("drain_valid", pix_valid, 1);
        mon_en = 0; prev_stall = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", pix_valid, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
        chk("arst_rd", ram_rd, 0); chk("arst_addr", 64'(ram_addr), 0); chk("arst_clr", bb_clear, 0);
        chk("arst_pix", pk(pix_x, pix_y, pix_data, pix_last), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
